// File: rtl/pcpi_loader_pkg.sv
// Shared types and sizing for the PCPI nibble loader slice.
package pcpi_loader_pkg;

  localparam int unsigned NIBBLES_PER_WORD = 8;
  localparam int unsigned NIBBLE_W         = 4;
  localparam int unsigned WORD_W           = NIBBLES_PER_WORD * NIBBLE_W;
  localparam int unsigned IDX_W            = $clog2(NIBBLES_PER_WORD);

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_SEND    = 2'd2
  } state_t;

endpackage

// File: rtl/pcpi_timeout_ctr.sv
// Idle-cycle counter for the ISSUE phase; flags the cycle whose count would reach the limit.
module pcpi_timeout_ctr #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic hold,
  input  logic enable,
  output logic expired
);

  localparam logic [7:0] LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] count;
  logic       advance;

  assign advance = enable && !hold && !clear;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (advance) begin
      count <= count + 8'd1;
    end
  end

  // Expiry is decoded on the increment that reaches the limit, so the abort
  // lands after exactly TIMEOUT_CYCLES idle ISSUE cycles.
  assign expired = advance && (count == LAST);

endmodule

// File: rtl/pcpi_nibble_loader.sv
// Assembles 32-bit PCPI instructions from nibbles, issues them, and streams the result back as nibbles.
module pcpi_nibble_loader
  import pcpi_loader_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        nib_valid,
  input  logic [3:0]  nib_data,
  output logic        nib_ready,
  output logic        pcpi_valid,
  output logic [31:0] pcpi_insn,
  input  logic        pcpi_ready,
  input  logic        pcpi_wait,
  input  logic        pcpi_wr,
  input  logic [31:0] pcpi_rd,
  output logic        res_valid,
  output logic [3:0]  res_data,
  input  logic        res_ready,
  output logic        busy,
  output logic        err
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES_PER_WORD - 1);

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    k_q, j_q;
  logic [WORD_W-1:0]   insn_q, result_q;
  logic                pcpi_valid_q, err_q;
  logic                nib_fire, res_fire, last_nib, last_res;
  logic                tmo_enable, tmo_expired;

  assign nib_fire = nib_valid && nib_ready;
  assign res_fire = res_valid && res_ready;
  assign last_nib = nib_fire && (k_q == LAST_IDX);
  assign last_res = res_fire && (j_q == LAST_IDX);

  assign tmo_enable = (state_q == ST_ISSUE) && !pcpi_ready;

  pcpi_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (last_nib),
    .hold    (pcpi_wait),
    .enable  (tmo_enable),
    .expired (tmo_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_COLLECT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_COLLECT: if (last_nib) state_d = ST_ISSUE;
      ST_ISSUE: begin
        if (pcpi_ready)       state_d = pcpi_wr ? ST_SEND : ST_COLLECT;
        else if (tmo_expired) state_d = ST_COLLECT;
      end
      ST_SEND:    if (last_res) state_d = ST_COLLECT;
      default:    state_d = ST_COLLECT;
    endcase
  end

  always_comb begin
    nib_ready = (state_q == ST_COLLECT);
    res_valid = (state_q == ST_SEND);
    busy      = (state_q != ST_COLLECT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q          <= '0;
      j_q          <= '0;
      insn_q       <= '0;
      result_q     <= '0;
      pcpi_valid_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      if (nib_fire) begin
        for (int unsigned i = 0; i < NIBBLES_PER_WORD; i++) begin
          if (k_q == IDX_W'(i)) insn_q[i*NIBBLE_W +: NIBBLE_W] <= nib_data;
        end
        k_q <= last_nib ? '0 : k_q + IDX_W'(1);
        if (k_q == '0) err_q <= 1'b0;
      end
      if (last_nib) pcpi_valid_q <= 1'b1;

      if (state_q == ST_ISSUE) begin
        if (pcpi_ready) begin
          pcpi_valid_q <= 1'b0;
          if (pcpi_wr) result_q <= pcpi_rd;
        end else if (tmo_expired) begin
          pcpi_valid_q <= 1'b0;
          err_q        <= 1'b1;
        end
      end

      // The result is shifted out, so res_data is always the low nibble register.
      if (res_fire) begin
        result_q <= result_q >> NIBBLE_W;
        j_q      <= last_res ? '0 : j_q + IDX_W'(1);
      end
    end
  end

  assign pcpi_valid = pcpi_valid_q;
  assign pcpi_insn  = insn_q;
  assign res_data   = result_q[NIBBLE_W-1:0];
  assign err        = err_q;

endmodule

// File: tb/tb_pcpi_nibble_loader.sv
// Directed scoreboard bench for pcpi_nibble_loader with a short timeout limit.
module tb_pcpi_nibble_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        nib_valid = 1'b0;
  logic [3:0]  nib_data = '0;
  logic        nib_ready;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn;
  logic        pcpi_ready = 1'b0;
  logic        pcpi_wait = 1'b0;
  logic        pcpi_wr = 1'b0;
  logic [31:0] pcpi_rd = '0;
  logic        res_valid;
  logic [3:0]  res_data;
  logic        res_ready = 1'b0;
  logic        busy;
  logic        err;

  int checks = 0;
  int failures = 0;
  logic [3:0] exp_q[$];

  pcpi_nibble_loader #(
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .nib_valid  (nib_valid),
    .nib_data   (nib_data),
    .nib_ready  (nib_ready),
    .pcpi_valid (pcpi_valid),
    .pcpi_insn  (pcpi_insn),
    .pcpi_ready (pcpi_ready),
    .pcpi_wait  (pcpi_wait),
    .pcpi_wr    (pcpi_wr),
    .pcpi_rd    (pcpi_rd),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .res_ready  (res_ready),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_pcpi_valid"}, pcpi_valid, 0);
    chk({tag, "_pcpi_insn"},  pcpi_insn,  0);
    chk({tag, "_res_data"},   res_data,   0);
    chk({tag, "_err"},        err,        0);
    chk({tag, "_nib_ready"},  nib_ready,  1);
    chk({tag, "_res_valid"},  res_valid,  0);
    chk({tag, "_busy"},       busy,       0);
  endtask

  task automatic send_nibbles(input logic [31:0] w, input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      nib_valid = 1'b1;
      nib_data  = w[i*4 +: 4];
      chk("nib_ready_collect", nib_ready, 1);
      step();
    end
    nib_valid = 1'b0;
  endtask

  task automatic push_result(input logic [31:0] rd);
    for (int i = 0; i < 8; i++) exp_q.push_back(rd[i*4 +: 4]);
  endtask

  task automatic drain(input int stall_at, input int stall_len);
    int j = 0;
    int stalled = 0;
    int budget = 0;
    while (exp_q.size() > 0 && budget < 64) begin
      budget++;
      chk("res_valid_send", res_valid, 1);
      if (j == stall_at && stalled < stall_len) begin
        res_ready = 1'b0;
        chk("res_hold", res_data, exp_q[0]);
        stalled++;
      end else begin
        res_ready = 1'b1;
        chk("res_data", res_data, exp_q.pop_front());
        j++;
      end
      step();
    end
    res_ready = 1'b0;
    chk("sb_drained", exp_q.size(), 0);
  endtask

  initial begin
    logic [31:0] w;
    logic [31:0] insn_before;

    #2;
    chk_reset_outputs("rst");
    #10 rst_n = 1'b1;
    step();

    // Assemble 0x20000013 from nibbles 3,1,0,0,0,0,0,2.
    send_nibbles(32'h2000_0013, 0, 8);
    chk("issue_valid", pcpi_valid, 1);
    chk("issue_insn",  pcpi_insn,  32'h2000_0013);
    chk("issue_nib_ready", nib_ready, 0);
    chk("issue_busy", busy, 1);

    // Stall in ISSUE while nibbles are offered; they must be ignored.
    insn_before = pcpi_insn;
    pcpi_wait = 1'b1;
    nib_valid = 1'b1;
    nib_data  = 4'hF;
    repeat (3) begin
      step();
      chk("issue_hold_valid", pcpi_valid, 1);
      chk("issue_hold_insn",  pcpi_insn,  insn_before);
    end
    nib_valid = 1'b0;

    // Result 0xDEADBEEF streamed with a 3-cycle consumer stall at j=2.
    pcpi_wait  = 1'b0;
    pcpi_ready = 1'b1;
    pcpi_wr    = 1'b1;
    pcpi_rd    = 32'hDEAD_BEEF;
    push_result(pcpi_rd);
    step();
    pcpi_ready = 1'b0;
    pcpi_wr    = 1'b0;
    chk("send_valid_dropped", pcpi_valid, 0);
    chk("send_busy", busy, 1);
    drain(2, 3);
    chk("post_send_res_valid", res_valid, 0);
    chk("post_send_nib_ready", nib_ready, 1);
    chk("post_send_err", err, 0);

    // Timeout after 4 idle ISSUE cycles.
    send_nibbles(32'h00A0_0093, 0, 8);
    for (int c = 0; c < 4; c++) begin
      chk("tmo_valid_held", pcpi_valid, 1);
      chk("tmo_err_low", err, 0);
      step();
    end
    chk("tmo_err", err, 1);
    chk("tmo_valid_dropped", pcpi_valid, 0);
    chk("tmo_nib_ready", nib_ready, 1);

    // First nibble of the next instruction clears err; then a long co-processor wait.
    w = 32'h0223_0333;
    send_nibbles(w, 0, 1);
    chk("err_cleared", err, 0);
    pcpi_wait = 1'b1;
    send_nibbles(w, 1, 7);
    chk("wait_insn", pcpi_insn, w);
    repeat (20) begin
      step();
      chk("wait_no_err", err, 0);
    end
    chk("wait_valid_held", pcpi_valid, 1);
    pcpi_wait  = 1'b0;
    pcpi_ready = 1'b1;
    pcpi_wr    = 1'b1;
    pcpi_rd    = $urandom;
    push_result(pcpi_rd);
    step();
    pcpi_ready = 1'b0;
    pcpi_wr    = 1'b0;
    chk("wait_accept_err", err, 0);
    drain(-1, 0);

    // pcpi_ready without pcpi_wr returns straight to COLLECT.
    send_nibbles(32'h1234_5678, 0, 8);
    pcpi_ready = 1'b1;
    pcpi_rd    = 32'hCAFE_F00D;
    step();
    pcpi_ready = 1'b0;
    chk("nowr_valid", pcpi_valid, 0);
    chk("nowr_res_valid", res_valid, 0);
    chk("nowr_nib_ready", nib_ready, 1);
    chk("nowr_busy", busy, 0);
    step();
    chk("nowr_res_valid_later", res_valid, 0);

    // Reset after the 5th nibble, then a fresh instruction.
    send_nibbles(32'h9876_5A5B, 0, 5);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    step();
    rst_n = 1'b1;
    step();
    w = 32'hFEDC_BA98;
    send_nibbles(w, 0, 8);
    chk("fresh_insn", pcpi_insn, w);
    chk("fresh_valid", pcpi_valid, 1);
    pcpi_ready = 1'b1;
    pcpi_wr    = 1'b1;
    pcpi_rd    = 32'h0F1E_2D3C;
    push_result(pcpi_rd);
    step();
    pcpi_ready = 1'b0;
    pcpi_wr    = 1'b0;
    drain(5, 1);
    chk("final_nib_ready", nib_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pcpi_nibble_loader.md
PCPI_NIBBLE_LOADER -- requirements
Module: pcpi_nibble_loader

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, max cycles in ISSUE with pcpi_wait low before abort (1..255).
REQ-002 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port nib_valid, input, 1, instruction nibble present this cycle.
REQ-005 SHALL have port nib_data, input, 4, instruction nibble.
REQ-006 SHALL have port nib_ready, output, 1, nibble accepted when nib_valid and nib_ready are both high.
REQ-007 SHALL have port pcpi_valid, output, 1, instruction offered to the PCPI co-processor.
REQ-008 SHALL have port pcpi_insn, output, 32, assembled instruction.
REQ-009 SHALL have ports pcpi_ready (input, 1, co-processor done), pcpi_wait (input, 1, co-processor busy) and pcpi_wr (input, 1, result valid).
REQ-010 SHALL have port pcpi_rd, input, 32, co-processor result.
REQ-011 SHALL have ports res_valid (output, 1), res_data (output, 4, result nibble) and res_ready (input, 1, consumer accepts).
REQ-012 SHALL have ports busy (output, 1, not in COLLECT) and err (output, 1, sticky timeout flag).

Function
REQ-013 SHALL implement states COLLECT, ISSUE, SEND.
REQ-014 In COLLECT, nib_ready SHALL be 1; each handshake writes nib_data to pcpi_insn[4k+3:4k] (k = nibble count 0..7, first nibble = bits 3:0) and increments k.
REQ-015 The handshake at k=7 SHALL move to ISSUE next cycle, reset k to 0 and assert pcpi_valid (registered); nib_ready SHALL be 0 outside COLLECT.
REQ-016 In ISSUE, pcpi_valid and pcpi_insn SHALL hold stable until pcpi_ready is sampled high.
REQ-017 On pcpi_ready with pcpi_wr=1, the block SHALL latch pcpi_rd, drop pcpi_valid and move to SEND; with pcpi_wr=0 it SHALL drop pcpi_valid and return to COLLECT.
REQ-018 In ISSUE, an 8-bit timeout counter SHALL increment each cycle pcpi_wait=0 and pcpi_ready=0, hold while pcpi_wait=1, and clear on entry to ISSUE.
REQ-019 When the counter reaches TIMEOUT_CYCLES, the block SHALL set err, drop pcpi_valid and return to COLLECT; pcpi_ready in the same cycle SHALL take priority over the timeout.
REQ-020 In SEND, res_valid SHALL be 1 and res_data SHALL equal result nibble j (j=0 first, bits 3:0); each res_valid and res_ready handshake increments j.
REQ-021 The SEND handshake at j=7 SHALL return to COLLECT with j=0; res_data SHALL hold stable while res_valid=1 and res_ready=0.
REQ-022 err SHALL clear on the first nibble handshake of the next instruction (k=0).
REQ-023 Nibble input during ISSUE or SEND SHALL be ignored, with no change to pcpi_insn or k.
REQ-024 All outputs SHALL be registered except nib_ready, res_valid and busy, which decode state only.

Reset
REQ-025 Asserting rst_n low at any time, including mid-COLLECT, ISSUE or SEND, SHALL immediately force: state COLLECT, k=0, j=0, timeout counter 0, pcpi_valid=0, pcpi_insn=0, result register 0, err=0.
REQ-026 After reset deassertion, the first handshake SHALL load nibble 0.

Structure
REQ-027 The state enum, NIBBLES_PER_WORD=8 and NIBBLE_W=4 SHALL live in shared package pcpi_loader_pkg.
REQ-028 The timeout counter SHALL be a separate sub-module, pcpi_timeout_ctr (inputs: clear, hold, enable; output: expired).

Verification
REQ-029 Nibbles 3,1,0,0,0,0,0,2 on consecutive cycles -> pcpi_insn=0x20000013 and pcpi_valid=1 one cycle after the 8th nibble.
REQ-030 ISSUE, then pcpi_ready=1, pcpi_wr=1, pcpi_rd=0xDEADBEEF -> res_data sequence F,E,E,B,D,A,E,D; with res_ready stalled 3 cycles at j=2, res_data stays E.
REQ-031 TIMEOUT_CYCLES=4, no pcpi_ready, pcpi_wait=0 -> err=1 and pcpi_valid=0 after 4 ISSUE cycles; the next nibble clears err.
REQ-032 pcpi_wait=1 for 20 cycles, then pcpi_ready with TIMEOUT_CYCLES=4 -> no err and result accepted.
REQ-033 rst_n low after the 5th nibble -> all outputs reset; a fresh 8-nibble instruction then assembles correctly.
REQ-034 pcpi_ready=1 with pcpi_wr=0 -> return to COLLECT, res_valid never asserted, and nib_ready=1 on the next cycle.
